// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with writeback data select and a retired-instruction
// counter for the pipelined LEGv8 CPU. Outputs depend only on registered state.
module mem_wb_stage #(
  parameter int DW = 64,
  parameter int RW = 5,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          flush,
  input  logic          mem_valid,
  input  logic          MemtoReg_in,
  input  logic          RegWrite_in,
  input  logic          ldurb_in,
  input  logic [RW-1:0] rd_in,
  input  logic [DW-1:0] dm_address,
  input  logic [DW-1:0] dm_read_data,
  output logic          wb_valid,
  output logic          wb_reg_write,
  output logic [RW-1:0] wb_rd,
  output logic [DW-1:0] wb_data,
  output logic          fwd_en,
  output logic [CW-1:0] retired
);

  logic          valid_q;
  logic          RegWrite_q;
  logic          MemtoReg_q;
  logic          ldurb_q;
  logic [RW-1:0] rd_q;
  logic [DW-1:0] alu_q;
  logic [DW-1:0] rdata_q;
  logic [CW-1:0] retired_q;
  logic [DW-1:0] load_val;
  logic          is_xzr;

  assign is_xzr = (rd_in == RW'(31));

  // A flush only kills the slot's validity and write enable; the data fields keep
  // loading so the writeback mux always sees defined values on a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      RegWrite_q <= 1'b0;
      MemtoReg_q <= 1'b0;
      ldurb_q    <= 1'b0;
      rd_q       <= '0;
      alu_q      <= '0;
      rdata_q    <= '0;
      retired_q  <= '0;
    end else if (!stall) begin
      if (valid_q)
        retired_q <= retired_q + CW'(1);
      valid_q    <= flush ? 1'b0 : mem_valid;
      RegWrite_q <= flush ? 1'b0 : (RegWrite_in & ~is_xzr);
      MemtoReg_q <= MemtoReg_in;
      ldurb_q    <= ldurb_in;
      rd_q       <= rd_in;
      alu_q      <= dm_address;
      rdata_q    <= dm_read_data;
    end
  end

  always_comb begin
    load_val = ldurb_q ? {{(DW-8){1'b0}}, rdata_q[7:0]} : rdata_q;
    wb_data  = MemtoReg_q ? load_val : alu_q;
  end

  assign wb_valid     = valid_q;
  assign wb_reg_write = valid_q & RegWrite_q;
  assign fwd_en       = valid_q & RegWrite_q;
  assign wb_rd        = rd_q;
  assign retired      = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Table-driven self-checking bench for mem_wb_stage (CW=4 so the retire counter wraps).
module tb_mem_wb_stage;

  logic        clk;
  logic        reset, stall, flush, mem_valid, MemtoReg_in, RegWrite_in, ldurb_in;
  logic [4:0]  rd_in;
  logic [63:0] dm_address, dm_read_data;
  logic        wb_valid, wb_reg_write, fwd_en;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic [3:0]  retired;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          rst, st, fl, mv, m2r, rw, lb;
    logic [4:0]  rd;
    logic [63:0] addr, rdata;
    bit          ev, ew;
    logic [4:0]  erd;
    logic [63:0] edata;
    bit          cd;
    logic [3:0]  eret;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[$];

  mem_wb_stage #(.DW(64), .RW(5), .CW(4)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .mem_valid(mem_valid),
    .MemtoReg_in(MemtoReg_in), .RegWrite_in(RegWrite_in), .ldurb_in(ldurb_in),
    .rd_in(rd_in), .dm_address(dm_address), .dm_read_data(dm_read_data),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_data(wb_data), .fwd_en(fwd_en), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input bit rst, input bit st, input bit fl, input bit mv,
                              input bit m2r, input bit rw, input bit lb, input logic [4:0] rd,
                              input logic [63:0] addr, input logic [63:0] rdata,
                              input bit ev, input bit ew, input logic [4:0] erd,
                              input logic [63:0] edata, input bit cd, input logic [3:0] eret);
    vec_t v;
    v.rst = rst; v.st = st; v.fl = fl; v.mv = mv; v.m2r = m2r; v.rw = rw; v.lb = lb;
    v.rd = rd; v.addr = addr; v.rdata = rdata;
    v.ev = ev; v.ew = ew; v.erd = erd; v.edata = edata; v.cd = cd; v.eret = eret;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    vec_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s scoreboard empty got 0 entries expected 1", tag);
      return;
    end
    checks--;
    e = sb.pop_front();
    cmp({tag, " wb_valid"}, 64'(wb_valid), 64'(e.ev));
    cmp({tag, " wb_reg_write"}, 64'(wb_reg_write), 64'(e.ew));
    cmp({tag, " fwd_en"}, 64'(fwd_en), 64'(e.ew));
    cmp({tag, " retired"}, 64'(retired), 64'(e.eret));
    cmp({tag, " wb_data_known"}, 64'($isunknown(wb_data)), 64'(0));
    if (e.cd) begin
      cmp({tag, " wb_rd"}, 64'(wb_rd), 64'(e.erd));
      cmp({tag, " wb_data"}, wb_data, e.edata);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    @(negedge clk);
    reset = v.rst; stall = v.st; flush = v.fl; mem_valid = v.mv;
    MemtoReg_in = v.m2r; RegWrite_in = v.rw; ldurb_in = v.lb;
    rd_in = v.rd; dm_address = v.addr; dm_read_data = v.rdata;
    sb.push_back(v);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  localparam logic [63:0] D = 64'hDEADBEEF_CAFEF00D;

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; mem_valid = 1'b1; MemtoReg_in = 1'b0;
    RegWrite_in = 1'b1; ldurb_in = 1'b0; rd_in = 5'd3; dm_address = '0; dm_read_data = '0;

    //            rst st fl mv m2r rw lb rd     addr        rdata                   ev ew erd    edata       cd ret
    tbl.push_back(mk(1, 0, 0, 1, 0, 1, 0, 5'd3,  64'h55,     64'h0,                  0, 0, 5'd0,  64'h0,      1, 4'd0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 1, 0, 5'd3,  64'h55,     64'h0,                  0, 0, 5'd0,  64'h0,      1, 4'd0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0, 5'd5,  64'h1234,   64'h0,                  1, 1, 5'd5,  64'h1234,   1, 4'd0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, 5'd6,  64'h99,     D,                      1, 1, 5'd6,  D,          1, 4'd1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 1, 5'd7,  64'h99,     D,                      1, 1, 5'd7,  64'h0D,     1, 4'd2));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0, 5'd7,  64'h777,    64'h0,                  1, 1, 5'd7,  64'h777,    1, 4'd3));
    tbl.push_back(mk(0, 1, 0, 1, 0, 1, 0, 5'd9,  64'hAAAA,   64'h0,                  1, 1, 5'd7,  64'h777,    1, 4'd3));
    tbl.push_back(mk(0, 1, 0, 1, 1, 1, 1, 5'd10, 64'hBBBB,   64'hFF,                 1, 1, 5'd7,  64'h777,    1, 4'd3));
    tbl.push_back(mk(0, 1, 1, 1, 0, 1, 0, 5'd11, 64'hCCCC,   64'h0,                  1, 1, 5'd7,  64'h777,    1, 4'd3));
    tbl.push_back(mk(0, 0, 1, 1, 0, 1, 0, 5'd12, 64'hCCCC,   64'h0,                  0, 0, 5'd0,  64'h0,      0, 4'd4));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0, 5'd31, 64'h31,     64'h0,                  1, 0, 5'd31, 64'h31,     1, 4'd4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 5'd2,  64'h22,     64'h0,                  0, 0, 5'd2,  64'h22,     1, 4'd5));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1, 5'd3,  64'h0,      64'h1122334455667788,   1, 0, 5'd3,  64'h88,     1, 4'd5));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0, 5'd4,  64'h0,      64'h0,                  1, 1, 5'd4,  64'h0,      1, 4'd6));

    for (int i = 0; i < tbl.size(); i++)
      applyStimulus(tbl[i], $sformatf("vec%0d", i));

    // Counter wrap: after reset, instruction k retires on edge k+1, so retired reads (k-1) mod 16.
    applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 5'd0, 64'h0, 64'h0, 0, 0, 5'd0, 64'h0, 1, 4'd0), "wrap_rst");
    for (int k = 1; k <= 18; k++)
      applyStimulus(mk(0, 0, 0, 1, 0, 1, 0, 5'd1, 64'(k), 64'h0, 1, 1, 5'd1, 64'(k), 1, 4'((k - 1) % 16)),
                    $sformatf("wrap%0d", k));

    // Reset arriving while a valid instruction is held by stall.
    applyStimulus(mk(0, 0, 0, 1, 0, 1, 0, 5'd8, 64'h88, 64'h0, 1, 1, 5'd8, 64'h88, 1, 4'd2), "rs_cap");
    applyStimulus(mk(0, 1, 0, 1, 0, 1, 0, 5'd9, 64'h99, 64'h0, 1, 1, 5'd8, 64'h88, 1, 4'd2), "rs_hold");
    applyStimulus(mk(1, 1, 0, 1, 0, 1, 0, 5'd9, 64'h99, 64'h0, 0, 0, 5'd0, 64'h0, 1, 4'd0), "rs_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register and writeback select for the pipelined LEGv8 CPU.
- Sits directly downstream of the data-memory stage. Captures the ALU result, the data-memory read data, the destination register and the writeback controls.
- Drives the register-file write port and the forwarding unit's WB-stage inputs. Also keeps a retired-instruction counter.

Parameters:
- DW, 64, datapath width.
- RW, 5, register index width.
- CW, 32, retire counter width.

Ports:
- clk  in  1  Clock; all state updates on the rising edge.
- reset  in  1  Synchronous, active-high reset.
- stall  in  1  Hold all MEM/WB state; has priority below reset, above flush.
- flush  in  1  Load a bubble instead of the incoming instruction.
- mem_valid  in  1  Incoming MEM-stage slot holds a real instruction.
- MemtoReg_in  in  1  Select load data (1) or ALU result (0) for writeback.
- RegWrite_in  in  1  Instruction writes the register file.
- ldurb_in  in  1  Byte load: zero-extend the low byte of the read data.
- rd_in  in  RW  Destination register index.
- dm_address  in  DW  ALU result / memory address from the MEM stage.
- dm_read_data  in  DW  Data-memory read data, valid in the same cycle as the MEM slot.
- wb_valid  out  1  WB slot holds a real instruction.
- wb_reg_write  out  1  Register-file write enable.
- wb_rd  out  RW  Register-file write index.
- wb_data  out  DW  Register-file write data.
- fwd_en  out  1  Forwarding candidate valid.
- retired  out  CW  Count of retired instructions.

Behaviour:
- Reset (reset=1 at an edge):
  - Clear all registers: wb_valid=0, RegWrite_q=0, MemtoReg_q=0, ldurb_q=0, rd_q=0, alu_q=0, rdata_q=0, retired=0.
  - Reset overrides stall and flush.
  - Reset asserted mid-stall discards the held instruction.
- Normal capture (stall=0, flush=0):
  - Each register loads its *_in counterpart on the edge.
  - valid_q <= mem_valid; alu_q <= dm_address; rdata_q <= dm_read_data.
  - Latency from the MEM-stage inputs to the WB outputs is exactly 1 cycle.
- Stall (stall=1, reset=0): every register holds, including valid_q, and retired does not increment. flush is ignored while stall=1.
- Flush (flush=1, stall=0, reset=0):
  - valid_q <= 0 and RegWrite_q <= 0.
  - The data registers may load or hold; their values are don't-care, but wb_data must not be X on a bubble.
- Register 31 (XZR): if rd_in == 31, RegWrite_q loads 0 regardless of RegWrite_in.
- Combinational outputs:
  - wb_reg_write = valid_q & RegWrite_q.
  - wb_rd = rd_q.
  - load_val = ldurb_q ? {56'b0, rdata_q[7:0]} : rdata_q.
  - wb_data = MemtoReg_q ? load_val : alu_q.
  - fwd_en = wb_reg_write.
  - wb_valid = valid_q.
- Retire counter:
  - Increments by 1 on each edge where reset=0, stall=0 and valid_q=1, i.e. the current WB slot retires.
  - Wraps modulo 2^CW: from all-ones to 0, with no sticky flag.
- Simultaneous events: priority is reset > stall > flush > capture.
- No combinational path from any input to any output; all outputs derive from registers only.

Test Plan:
- Reset: hold reset=1 for 2 cycles with mem_valid=1, RegWrite_in=1, rd_in=3 -> wb_valid=0, wb_reg_write=0, wb_data=0, retired=0 after the first edge.
- ALU writeback: dm_address=0x1234, MemtoReg_in=0, RegWrite_in=1, rd_in=5, mem_valid=1 -> next cycle wb_reg_write=1, wb_rd=5, wb_data=0x1234; retired increments on the following edge.
- Loads:
  - dm_read_data=0xDEADBEEF_CAFEF00D, MemtoReg_in=1, ldurb_in=0 -> wb_data=0xDEADBEEFCAFEF00D.
  - Same data with ldurb_in=1 -> wb_data=0x0D.
- Stall/flush:
  - Capture rd=7, then stall=1 for 3 cycles while the inputs change -> wb_rd stays 7, wb_data unchanged, retired frozen.
  - stall=1 with flush=1 simultaneously -> still held.
  - flush=1 alone -> wb_valid=0, wb_reg_write=0.
- XZR and bubbles:
  - rd_in=31, RegWrite_in=1 -> wb_reg_write=0 and wb_valid=1; retired still increments.
  - mem_valid=0 -> wb_reg_write=0 and no increment.
- Counter wrap (CW=4): retire 17 consecutive valid instructions -> retired goes 15->0->1.
- Reset during stall: hold a valid instruction with stall=1, then pulse reset -> all outputs 0 on the next edge.
